// File: rtl/sys_defs_pkg.sv
// Shared definitions for the reorder buffer and its neighbours:
// datapath widths, the CDB broadcast format, and the ROB entry / retire bundles.
package sys_defs;

    localparam int XLEN           = 32;
    localparam int ROB_SZ_DEFAULT = 16;
    // Tag width carried on the CDB; any instantiated ROB must be no larger than the default.
    localparam int TAG_W          = $clog2(ROB_SZ_DEFAULT);

    typedef logic [31:0] INST;

    // Completion broadcast from the write-result stage.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] value;
        logic [TAG_W-1:0] rob_tag;
    } CDB_DATA;

    // One reorder-buffer slot.
    typedef struct packed {
        logic            valid;
        logic            complete;
        logic            mispredict;
        logic [4:0]      dest;
        logic [XLEN-1:0] value;
        INST             inst;
        logic [XLEN-1:0] NPC;
    } ROB_ENTRY;

    // Everything the retire port presents in one cycle.
    typedef struct packed {
        logic             valid;
        logic [4:0]       dest;
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
        INST              inst;
        logic [XLEN-1:0]  NPC;
        logic             squash;
    } ROB_RETIRE_PACKET;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation from dispatch, out-of-order completion
// from the CDB, in-order single retire per cycle, operand lookup with CDB
// bypass, and a full flush when a mispredicted branch commits.
module rob
    import sys_defs::*;
#(
    parameter int ROB_SZ = ROB_SZ_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      dispatch_valid,
    input  logic [4:0]                dispatch_dest,
    input  INST                       dispatch_inst,
    input  logic [XLEN-1:0]           dispatch_NPC,
    output logic [$clog2(ROB_SZ)-1:0] dispatch_tag,
    output logic                      rob_full,
    input  CDB_DATA                   cdb,
    input  logic                      mispredict_valid,
    input  logic [$clog2(ROB_SZ)-1:0] mispredict_tag,
    input  logic [1:0][$clog2(ROB_SZ)-1:0] rs_tag,
    output logic [1:0]                rs_ready,
    output logic [1:0][XLEN-1:0]      rs_value,
    output logic                      retire_valid,
    output logic [4:0]                retire_dest,
    output logic [XLEN-1:0]           retire_value,
    output logic [$clog2(ROB_SZ)-1:0] retire_tag,
    output INST                       retire_inst,
    output logic [XLEN-1:0]           retire_NPC,
    output logic                      squash
);

    localparam int ROB_TAG_W = $clog2(ROB_SZ);
    localparam int CNT_W     = ROB_TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ROB_SZ);

    ROB_ENTRY             r_entries [ROB_SZ];
    logic [ROB_TAG_W-1:0] r_head;
    logic [ROB_TAG_W-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    ROB_ENTRY             w_head_entry;
    ROB_RETIRE_PACKET     w_retire_pkt;
    logic                 w_full;
    logic                 w_dispatch;
    logic                 w_retire;
    logic                 w_squash;
    logic [ROB_TAG_W-1:0] w_cdb_tag;
    logic                 w_unused_bits;

    // Full is a function of registered count only: a retire this cycle does not free a slot for dispatch this cycle.
    assign w_full       = (r_count == FULL_COUNT);
    assign w_dispatch   = dispatch_valid && !w_full;
    assign w_head_entry = r_entries[r_head];
    assign w_retire     = w_head_entry.valid && w_head_entry.complete;
    assign w_squash     = w_retire && w_head_entry.mispredict;
    assign w_cdb_tag    = cdb.rob_tag[ROB_TAG_W-1:0];
    // Upper CDB tag bits are zero whenever this ROB is smaller than the default.
    assign w_unused_bits = ^{cdb.rob_tag, w_retire_pkt.tag};

    // Entry array, pointers and occupancy; later assignments win (dispatch over CDB on the same slot).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_squash) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < ROB_SZ; i++) begin
                if (cdb.valid && (w_cdb_tag == ROB_TAG_W'(i)) && r_entries[i].valid) begin
                    r_entries[i].complete <= 1'b1;
                    r_entries[i].value    <= cdb.value;
                end
                if (mispredict_valid && (mispredict_tag == ROB_TAG_W'(i)) && r_entries[i].valid) begin
                    r_entries[i].mispredict <= 1'b1;
                end
            end
            if (w_retire) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + ROB_TAG_W'(1);
            end
            if (w_dispatch) begin
                r_entries[r_tail] <= '{valid:      1'b1,
                                       complete:   1'b0,
                                       mispredict: 1'b0,
                                       dest:       dispatch_dest,
                                       value:      '0,
                                       inst:       dispatch_inst,
                                       NPC:        dispatch_NPC};
                r_tail <= r_tail + ROB_TAG_W'(1);
            end
            case ({w_dispatch, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Retire bundle from the head entry; zeroed when nothing retires.
    always_comb begin
        w_retire_pkt = '0;
        if (w_retire) begin
            w_retire_pkt.valid  = 1'b1;
            w_retire_pkt.dest   = w_head_entry.dest;
            w_retire_pkt.value  = w_head_entry.value;
            w_retire_pkt.tag    = TAG_W'(r_head);
            w_retire_pkt.inst   = w_head_entry.inst;
            w_retire_pkt.NPC    = w_head_entry.NPC;
            w_retire_pkt.squash = w_head_entry.mispredict;
        end
    end

    assign retire_valid = w_retire_pkt.valid;
    assign retire_dest  = w_retire_pkt.dest;
    assign retire_value = w_retire_pkt.value;
    assign retire_tag   = w_retire_pkt.tag[ROB_TAG_W-1:0];
    assign retire_inst  = w_retire_pkt.inst;
    assign retire_NPC   = w_retire_pkt.NPC;
    assign squash       = w_squash;
    assign dispatch_tag = r_tail;
    assign rob_full     = w_full;

    // Operand lookup per port: a completed entry first, otherwise the value on the CDB this cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
            logic w_hit_entry;
            logic w_hit_cdb;
            assign w_hit_entry   = r_entries[rs_tag[gi]].valid && r_entries[rs_tag[gi]].complete;
            assign w_hit_cdb     = cdb.valid && (w_cdb_tag == rs_tag[gi]);
            assign rs_ready[gi]  = w_hit_entry || w_hit_cdb;
            assign rs_value[gi]  = w_hit_entry ? r_entries[rs_tag[gi]].value :
                                   w_hit_cdb   ? cdb.value : '0;
        end
    endgenerate

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer at ROB_SZ = 4: a vector table walks
// allocation, completion, in-order retire, wrap, full, lookup bypass and
// squash; hand-written sequences cover reset state and asynchronous reset.
module tb_rob;
    import sys_defs::*;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            dispatch_valid = 1'b0;
    logic [4:0]      dispatch_dest = '0;
    INST             dispatch_inst = '0;
    logic [XLEN-1:0] dispatch_NPC = '0;
    logic [1:0]      dispatch_tag;
    logic            rob_full;
    CDB_DATA         cdb = '0;
    logic            mispredict_valid = 1'b0;
    logic [1:0]      mispredict_tag = '0;
    logic [1:0][1:0] rs_tag = '0;
    logic [1:0]      rs_ready;
    logic [1:0][XLEN-1:0] rs_value;
    logic            retire_valid;
    logic [4:0]      retire_dest;
    logic [XLEN-1:0] retire_value;
    logic [1:0]      retire_tag;
    INST             retire_inst;
    logic [XLEN-1:0] retire_NPC;
    logic            squash;

    rob #(.ROB_SZ(N)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
        .dispatch_inst(dispatch_inst), .dispatch_NPC(dispatch_NPC),
        .dispatch_tag(dispatch_tag), .rob_full(rob_full),
        .cdb(cdb), .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
        .rs_tag(rs_tag), .rs_ready(rs_ready), .rs_value(rs_value),
        .retire_valid(retire_valid), .retire_dest(retire_dest), .retire_value(retire_value),
        .retire_tag(retire_tag), .retire_inst(retire_inst), .retire_NPC(retire_NPC),
        .squash(squash)
    );

    always #5 clock = ~clock;

    typedef struct {
        int dv; int dest; int cv; int ctag; logic [31:0] cval; int mv; int mtag; int rs0;
        int e_dtag; int e_full; int e_rv; int e_rdest; logic [31:0] e_rval; int e_rtag;
        int e_sq; int e_cnt; int e_rdy0; logic [31:0] e_val0; int e_rdy1; logic [31:0] e_val1;
    } vec_t;

    vec_t vecs [23];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int dv, input int dest, input int cv, input int ctag,
                         input logic [31:0] cval, input int mv, input int mtag, input int rs0);
        dispatch_valid   = (dv != 0);
        dispatch_dest    = 5'(dest);
        dispatch_inst    = 32'h1000 + 32'(dest);
        dispatch_NPC     = 32'h4000 + 32'(dest * 4);
        cdb.valid        = (cv != 0);
        cdb.rob_tag      = TAG_W'(ctag);
        cdb.value        = cval;
        mispredict_valid = (mv != 0);
        mispredict_tag   = 2'(mtag);
        rs_tag[0]        = 2'(rs0);
        rs_tag[1]        = 2'd0;
    endtask

    initial begin
        //           dv dst cv ct cval     mv mt rs0  dtag full rv rdst rval     rtag sq cnt rdy0 val0     rdy1 val1
        vecs[0]  = '{1, 3, 0, 0, 0,        0, 0, 1,   0, 0, 0, 0,  0,        0, 0, 0, 0, 0,        0, 0};
        vecs[1]  = '{1, 5, 0, 0, 0,        0, 0, 1,   1, 0, 0, 0,  0,        0, 0, 1, 0, 0,        0, 0};
        vecs[2]  = '{1, 7, 0, 0, 0,        0, 0, 1,   2, 0, 0, 0,  0,        0, 0, 2, 0, 0,        0, 0};
        vecs[3]  = '{0, 0, 1, 1, 'hAA,     0, 0, 1,   3, 0, 0, 0,  0,        0, 0, 3, 1, 'hAA,     0, 0};
        vecs[4]  = '{0, 0, 1, 0, 'h55,     0, 0, 1,   3, 0, 0, 0,  0,        0, 0, 3, 1, 'hAA,     1, 'h55};
        vecs[5]  = '{0, 0, 0, 0, 0,        0, 0, 1,   3, 0, 1, 3,  'h55,     0, 0, 3, 1, 'hAA,     1, 'h55};
        vecs[6]  = '{0, 0, 0, 0, 0,        0, 0, 1,   3, 0, 1, 5,  'hAA,     1, 0, 2, 1, 'hAA,     0, 0};
        vecs[7]  = '{0, 0, 1, 2, 'h1234,   0, 0, 2,   3, 0, 0, 0,  0,        0, 0, 1, 1, 'h1234,   0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0,        0, 0, 2,   3, 0, 1, 7,  'h1234,   2, 0, 1, 1, 'h1234,   0, 0};
        vecs[9]  = '{1, 10, 0, 0, 0,       0, 0, 2,   3, 0, 0, 0,  0,        0, 0, 0, 0, 0,        0, 0};
        vecs[10] = '{1, 11, 0, 0, 0,       0, 0, 3,   0, 0, 0, 0,  0,        0, 0, 1, 0, 0,        0, 0};
        vecs[11] = '{1, 12, 0, 0, 0,       0, 0, 3,   1, 0, 0, 0,  0,        0, 0, 2, 0, 0,        0, 0};
        vecs[12] = '{1, 13, 0, 0, 0,       0, 0, 3,   2, 0, 0, 0,  0,        0, 0, 3, 0, 0,        0, 0};
        vecs[13] = '{1, 14, 0, 0, 0,       0, 0, 3,   3, 1, 0, 0,  0,        0, 0, 4, 0, 0,        0, 0};
        vecs[14] = '{1, 14, 1, 3, 'h33,    0, 0, 3,   3, 1, 0, 0,  0,        0, 0, 4, 1, 'h33,     0, 0};
        vecs[15] = '{1, 15, 0, 0, 0,       0, 0, 3,   3, 1, 1, 10, 'h33,     3, 0, 4, 1, 'h33,     0, 0};
        vecs[16] = '{1, 15, 0, 0, 0,       0, 0, 3,   3, 0, 0, 0,  0,        0, 0, 3, 0, 0,        0, 0};
        vecs[17] = '{0, 0, 1, 0, 'h100,    0, 0, 3,   0, 1, 0, 0,  0,        0, 0, 4, 0, 0,        1, 'h100};
        vecs[18] = '{0, 0, 1, 1, 'h101,    1, 1, 1,   0, 1, 1, 11, 'h100,    0, 0, 4, 1, 'h101,    1, 'h100};
        vecs[19] = '{1, 20, 1, 2, 'h222,   0, 0, 1,   0, 0, 1, 12, 'h101,    1, 1, 3, 1, 'h101,    0, 0};
        vecs[20] = '{1, 21, 0, 0, 0,       0, 0, 2,   0, 0, 0, 0,  0,        0, 0, 0, 0, 0,        0, 0};
        vecs[21] = '{0, 0, 1, 0, 'h77,     0, 0, 2,   1, 0, 0, 0,  0,        0, 0, 1, 0, 0,        1, 'h77};
        vecs[22] = '{0, 0, 0, 0, 0,        0, 0, 2,   1, 0, 1, 21, 'h77,     0, 0, 1, 0, 0,        1, 'h77};

        // Reset state
        #2;
        chk("reset retire_valid", 64'(retire_valid), 64'd0);
        chk("reset rob_full", 64'(rob_full), 64'd0);
        chk("reset squash", 64'(squash), 64'd0);
        chk("reset dispatch_tag", 64'(dispatch_tag), 64'd0);
        chk("reset count", 64'(dut.r_count), 64'd0);
        chk("reset rs_ready", 64'(rs_ready), 64'd0);
        #10 reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            vec_t v;
            logic [31:0] exp_inst;
            logic [31:0] exp_npc;
            @(negedge clock);
            v = vecs[i];
            drive(v.dv, v.dest, v.cv, v.ctag, v.cval, v.mv, v.mtag, v.rs0);
            #1;
            exp_inst = (v.e_rv != 0) ? 32'h1000 + 32'(v.e_rdest) : 32'd0;
            exp_npc  = (v.e_rv != 0) ? 32'h4000 + 32'(v.e_rdest * 4) : 32'd0;
            chk($sformatf("v%0d dispatch_tag", i), 64'(dispatch_tag), 64'(v.e_dtag));
            chk($sformatf("v%0d rob_full", i), 64'(rob_full), 64'(v.e_full));
            chk($sformatf("v%0d retire_valid", i), 64'(retire_valid), 64'(v.e_rv));
            chk($sformatf("v%0d retire_dest", i), 64'(retire_dest), 64'(v.e_rdest));
            chk($sformatf("v%0d retire_value", i), 64'(retire_value), 64'(v.e_rval));
            chk($sformatf("v%0d retire_tag", i), 64'(retire_tag), 64'(v.e_rtag));
            chk($sformatf("v%0d retire_inst", i), 64'(retire_inst), 64'(exp_inst));
            chk($sformatf("v%0d retire_NPC", i), 64'(retire_NPC), 64'(exp_npc));
            chk($sformatf("v%0d squash", i), 64'(squash), 64'(v.e_sq));
            chk($sformatf("v%0d count", i), 64'(dut.r_count), 64'(v.e_cnt));
            chk($sformatf("v%0d rs_ready0", i), 64'(rs_ready[0]), 64'(v.e_rdy0));
            chk($sformatf("v%0d rs_value0", i), 64'(rs_value[0]), 64'(v.e_val0));
            chk($sformatf("v%0d rs_ready1", i), 64'(rs_ready[1]), 64'(v.e_rdy1));
            chk($sformatf("v%0d rs_value1", i), 64'(rs_value[1]), 64'(v.e_val1));
            $display("vector %0d: dtag=%0d full=%0b rv=%0b rdest=%0d rval=%0h sq=%0b", i,
                     dispatch_tag, rob_full, retire_valid, retire_dest, retire_value, squash);
        end

        // Fill all four slots (head/tail at 1), then complete the head as a mispredicted branch.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive(1, 24 + k, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clock);
        drive(0, 0, 1, 1, 32'h9, 1, 1, 0);
        #1;
        chk("fill rob_full", 64'(rob_full), 64'd1);
        chk("fill count", 64'(dut.r_count), 64'd4);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre-reset retire_valid", 64'(retire_valid), 64'd1);
        chk("pre-reset squash", 64'(squash), 64'd1);
        chk("pre-reset retire_dest", 64'(retire_dest), 64'd24);

        // Asynchronous reset mid-cycle, well away from any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("async retire_valid", 64'(retire_valid), 64'd0);
        chk("async rob_full", 64'(rob_full), 64'd0);
        chk("async squash", 64'(squash), 64'd0);
        chk("async count", 64'(dut.r_count), 64'd0);
        chk("async dispatch_tag", 64'(dispatch_tag), 64'd0);
        $display("async reset: rv=%0b full=%0b sq=%0b", retire_valid, rob_full, squash);
        #1 reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
